// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - pipeline writeback/branch trace ring buffer with trigger and show-ahead readout
module pipe_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 16,
    parameter int POST   = 8,
    parameter int CYC_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RegWrite,
    input  logic [REG_AW-1:0]          A3,
    input  logic [DATA_W-1:0]          WD3,
    input  logic                       BranchTaken,
    input  logic [3:0]                 ALUFlags,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 trig_mode,
    input  logic [REG_AW-1:0]          trig_reg,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [REG_AW-1:0]          rd_reg,
    output logic [3:0]                 rd_flags,
    output logic                       rd_branch,
    output logic                       rd_wr,
    output logic [CYC_W-1:0]           rd_cycle,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 state,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + REG_AW + 4 + 1 + 1 + CYC_W;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
    localparam logic [CW-1:0] POST_LOAD = CW'(POST - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     post_q, post_d;
    logic              ovf_q, ovf_d;
    logic [CYC_W-1:0]  cyc_q;
    logic              ev, trig, we, full, start;
    logic [EW-1:0]     wr_entry, rd_entry;
    logic [EW-1:0]     mem [DEPTH];

    assign ev    = RegWrite | BranchTaken;
    assign trig  = (mode_q == 2'd2) ? BranchTaken : (RegWrite && (A3 == trig_reg));
    assign full  = (count_q == FULL_C);
    assign start = arm && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        post_d  = post_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (start) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            mode_d  = trig_mode;
            state_d = (trig_mode == 2'd0) ? S_CAPTURE : S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    we = (mode_q == 2'd3) ? ev : trig;
                    if (abort) begin
                        state_d = S_DONE;
                    end else if (trig) begin
                        if (mode_q == 2'd3) begin
                            post_d  = POST_LOAD;
                            state_d = (POST == 1) ? S_DONE : S_CAPTURE;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    we = (mode_q == 2'd3) ? ev : (ev && !full);
                    if (abort) begin
                        state_d = S_DONE;
                    end else if (we) begin
                        if (mode_q == 2'd3) begin
                            post_d = post_q - CW'(1);
                            if (post_q <= CW'(1)) state_d = S_DONE;
                        end else if (count_q == LAST_C) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_en && count_q != '0) begin
                        head_d  = head_q + AW'(1);
                        count_d = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
            // A write into a full ring drops the oldest entry instead of growing.
            if (we) begin
                tail_d = tail_q + AW'(1);
                if (full) begin
                    head_d = head_q + AW'(1);
                    ovf_d  = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            post_q  <= '0;
            ovf_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            post_q  <= post_d;
            ovf_q   <= ovf_d;
            cyc_q   <= cyc_q + CYC_W'(1);
        end
    end

    assign wr_entry = {WD3, A3, ALUFlags, BranchTaken, RegWrite, cyc_q};

    always_ff @(posedge clk) begin
        if (we) mem[tail_q] <= wr_entry;
    end

    assign rd_valid = (state_q == S_DONE) && (count_q != '0);
    assign rd_entry = rd_valid ? mem[head_q] : '0;
    assign {rd_data, rd_reg, rd_flags, rd_branch, rd_wr, rd_cycle} = rd_entry;
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - self-checking bench for pipe_trace_buffer
module tb_pipe_trace_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [3:0]  A3 = '0;
    logic [31:0] WD3 = '0;
    logic        BranchTaken = 1'b0;
    logic [3:0]  ALUFlags = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  trig_mode = '0;
    logic [3:0]  trig_reg = '0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  rd_reg;
    logic [3:0]  rd_flags;
    logic        rd_branch;
    logic        rd_wr;
    logic [15:0] rd_cycle;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int tb_cyc = 0;

    pipe_trace_buffer #(.DATA_W(32), .REG_AW(4), .DEPTH(16), .POST(4), .CYC_W(16)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .A3(A3), .WD3(WD3),
        .BranchTaken(BranchTaken), .ALUFlags(ALUFlags), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_reg(trig_reg), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_reg(rd_reg), .rd_flags(rd_flags), .rd_branch(rd_branch),
        .rd_wr(rd_wr), .rd_cycle(rd_cycle), .count(count), .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= reset ? tb_cyc + 1 : 0;

    typedef struct {
        logic [4:0]  cnt;
        logic [3:0]  rg;
        logic [31:0] data;
        logic [15:0] cyc;
    } vec_t;
    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic ev_wr(input logic [3:0] r, input logic [31:0] d);
        RegWrite = 1'b1; A3 = r; WD3 = d;
        step();
        RegWrite = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].cnt  = 5'(16 - i);
            vecs[i].cyc  = 16'(11 + i);
            vecs[i].rg   = 4'((11 + i) % 16);
            vecs[i].data = 32'(11 + i);
        end

        repeat (3) step();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);

        // Mode 0: arm in cycle 10, write every cycle.
        reset = 1'b1;
        for (int g = 0; g < 50 && tb_cyc != 10; g++) step();
        chk("m0_arm_cycle", 64'(tb_cyc), 64'd10);
        arm = 1'b1; trig_mode = 2'd0;
        RegWrite = 1'b1; A3 = 4'(tb_cyc % 16); WD3 = 32'(tb_cyc);
        step();
        arm = 1'b0;
        chk("m0_capture", 64'(state), 64'd2);
        for (int i = 0; i < 16; i++) begin
            A3 = 4'(tb_cyc % 16); WD3 = 32'(tb_cyc);
            step();
        end
        RegWrite = 1'b0;
        chk("m0_done", 64'(state), 64'd3);
        chk("m0_full", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("m0_valid", 64'(rd_valid), 64'd1);
            chk("m0_count", 64'(count), 64'(vecs[i].cnt));
            chk("m0_cycle", 64'(rd_cycle), 64'(vecs[i].cyc));
            chk("m0_reg", 64'(rd_reg), 64'(vecs[i].rg));
            chk("m0_data", 64'(rd_data), 64'(vecs[i].data));
            chk("m0_wr", 64'(rd_wr), 64'd1);
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk("m0_empty_count", 64'(count), 64'd0);
        chk("m0_empty_valid", 64'(rd_valid), 64'd0);

        // Mode 1: trigger on r5; later trig_mode changes must not matter.
        arm = 1'b1; trig_mode = 2'd1; trig_reg = 4'd5;
        step();
        arm = 1'b0; trig_mode = 2'd0;
        chk("m1_armed", 64'(state), 64'd1);
        for (int r = 1; r <= 4; r++) ev_wr(4'(r), 32'h100 + 32'(r));
        chk("m1_pre_count", 64'(count), 64'd0);
        chk("m1_pre_state", 64'(state), 64'd1);
        ev_wr(4'd5, 32'hDEADBEEF);
        chk("m1_trig_state", 64'(state), 64'd2);
        chk("m1_trig_count", 64'(count), 64'd1);
        for (int i = 0; i < 15; i++) ev_wr(4'd6, 32'(i));
        chk("m1_done", 64'(state), 64'd3);
        chk("m1_count", 64'(count), 64'd16);
        chk("m1_reg0", 64'(rd_reg), 64'd5);
        chk("m1_data0", 64'(rd_data), 64'hDEADBEEF);

        // Mode 3: pre-trigger ring, trigger on event 30, POST=4.
        arm = 1'b1; trig_mode = 2'd3; trig_reg = 4'd5;
        step();
        arm = 1'b0;
        for (int e = 0; e < 40; e++) begin
            ev_wr((e == 30) ? 4'd5 : 4'd1, 32'(e));
            if (e == 15) begin
                chk("m3_ovf_pre", 64'(overflow), 64'd0);
                chk("m3_cnt15", 64'(count), 64'd16);
            end
            if (e == 16) chk("m3_ovf_set", 64'(overflow), 64'd1);
            if (e == 29) chk("m3_armed", 64'(state), 64'd1);
            if (e == 32) chk("m3_cap32", 64'(state), 64'd2);
            if (e == 33) chk("m3_done33", 64'(state), 64'd3);
        end
        chk("m3_count", 64'(count), 64'd16);
        chk("m3_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk("m3_data", 64'(rd_data), 64'(18 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk("m3_drained", 64'(count), 64'd0);

        // Mode 2: branch trigger, then abort; arm clears sticky overflow.
        arm = 1'b1; trig_mode = 2'd2;
        step();
        arm = 1'b0;
        chk("m2_armed", 64'(state), 64'd1);
        chk("m2_ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) ev_wr(4'd1, 32'(i));
        chk("m2_pre_count", 64'(count), 64'd0);
        BranchTaken = 1'b1; ALUFlags = 4'b0100;
        step();
        BranchTaken = 1'b0; ALUFlags = 4'b0000;
        chk("m2_trig_state", 64'(state), 64'd2);
        ev_wr(4'd2, 32'h22);
        ev_wr(4'd3, 32'h33);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("m2_done", 64'(state), 64'd3);
        chk("m2_count", 64'(count), 64'd3);
        chk("m2_branch", 64'(rd_branch), 64'd1);
        chk("m2_flags", 64'(rd_flags), 64'b0100);
        chk("m2_wr0", 64'(rd_wr), 64'd0);

        // Reset mid-capture, then cycle stamp restarts at 0.
        arm = 1'b1; trig_mode = 2'd0;
        step();
        arm = 1'b0;
        for (int i = 0; i < 7; i++) ev_wr(4'd4, 32'(i));
        chk("rs_count7", 64'(count), 64'd7);
        chk("rs_cap", 64'(state), 64'd2);
        reset = 1'b0;
        step();
        chk("rs_state", 64'(state), 64'd0);
        chk("rs_count", 64'(count), 64'd0);
        chk("rs_valid", 64'(rd_valid), 64'd0);
        reset = 1'b1; arm = 1'b1; trig_mode = 2'd0;
        step();
        arm = 1'b0;
        RegWrite = 1'b1; A3 = 4'd2; WD3 = 32'h55; abort = 1'b1;
        step();
        RegWrite = 1'b0; abort = 1'b0;
        chk("rs_done", 64'(state), 64'd3);
        chk("rs_abort_wr", 64'(count), 64'd1);
        chk("rs_stamp", 64'(rd_cycle), 64'd1);
        chk("rs_data", 64'(rd_data), 64'h55);

        // DONE with two entries: rd_en held four cycles pops exactly two.
        arm = 1'b1; trig_mode = 2'd0;
        step();
        arm = 1'b0;
        ev_wr(4'd7, 32'hA0);
        ev_wr(4'd8, 32'hA1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("pp_count2", 64'(count), 64'd2);
        chk("pp_head", 64'(rd_data), 64'hA0);
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("pp_count", 64'(count), (k == 0) ? 64'd1 : 64'd0);
            chk("pp_valid", 64'(rd_valid), (k == 0) ? 64'd1 : 64'd0);
            if (k == 0) chk("pp_data1", 64'(rd_data), 64'hA1);
        end
        chk("pp_data_zero", 64'(rd_data), 64'd0);
        arm = 1'b1;
        step();
        arm = 1'b0; rd_en = 1'b0;
        chk("pp_rearm", 64'(state), 64'd2);
        chk("pp_rearm_cnt", 64'(count), 64'd0);
        chk("pp_rearm_ovf", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
